mult_eval_sequencer: RTL and testbench
======================================

# mult_eval_sequencer

On-chip evaluation sequencer for candidate multiplier architectures produced by the design-space exploration flow. It drives every operand pair into an external multiplier under test (DUT) and compares the DUT product against a golden A*B. It accumulates a mismatch count and a bit-error sum, and captures the first failing vector. Its results are the hardware-side reward signal for the exploration agent. It sits between the exploration harness (start/done) and one instantiated `multiplier` candidate.

## Interface
- `W`, default 2: operand width; DUT product width is 2W.
- `LAT`, default 0: DUT latency in cycles. 0 means combinational, with the product sampled in the same cycle its operands are driven.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a sweep; accepted only in IDLE.
- `busy`  out  1: high while in SWEEP or DRAIN.
- `done`  out  1: one-cycle pulse when results are final.
- `dut_a`, `dut_b`  out  W: registered operands to the DUT.
- `dut_p`  in  2W: DUT product.
- `err_cnt`  out  2W+1: number of vectors with `dut_p` ≠ golden.
- `bit_err_sum`  out  2W+clog2(2W)+1: sum over vectors of popcount(`dut_p` XOR golden).
- `ff_valid`  out  1: a first failing vector has been captured.
- `ff_a`, `ff_b`  out  W: operands of the first failing vector.
- `ff_p`  out  2W: DUT product of the first failing vector.

## Operation
- N = 2^(2W) vectors. Vector index k = {a, b}, with a in the upper W bits, ascending from 0 to N-1.
- FSM states:
  - IDLE: waiting for start.
    - `start`=1 → SWEEP.
    - In the acceptance cycle, clear `err_cnt`, `bit_err_sum`, `ff_*` and the index.
  - SWEEP: drive vector k per cycle.
    - After k=N-1: go to DRAIN if LAT>0, else DONE.
  - DRAIN: LAT cycles so the in-flight compares complete, then → DONE.
  - DONE: `done`=1 for one cycle, then → IDLE.
- Golden path: the golden product a*b (full 2W bits, unsigned) is delayed together with {a, b} and a valid bit through a LAT-deep pipe. The compare uses the pipe output against `dut_p` when valid=1.
- On a mismatch:
  - `err_cnt` += 1.
  - `bit_err_sum` += popcount of the difference.
  - If `ff_valid`=0: capture `ff_a`, `ff_b` and `ff_p`, and set `ff_valid`=1.
  - Later mismatches never overwrite the `ff_*` capture.
- Results hold from DONE until the next accepted `start`.
- `start` in SWEEP, DRAIN or DONE is ignored. It is not queued.
- `rst` at any point, including mid-sweep:
  - Next state is IDLE.
  - All outputs return to 0.
  - The valid pipe is flushed.
  - No `done` is issued for the aborted sweep.
- Counter widths are sized so no overflow is possible. No saturation logic is needed.

## Timing
- Reset values: `busy`=0, `done`=0, `dut_a`=`dut_b`=0, `err_cnt`=0, `bit_err_sum`=0, `ff_valid`=0, `ff_a`=`ff_b`=`ff_p`=0.
- `start` is sampled at cycle 0. The index for this timeline is k = 0..N-1.
- Cycle k+1: vector k appears on `dut_a`/`dut_b`.
- Cycle k+1+LAT: vector k is compared. The counters reflect it from cycle k+2+LAT.
- `busy`=1 for cycles 1 through N+LAT.
- `done`=1 at cycle N+LAT+1, with final values already visible. `busy`=0 in that cycle.
- After the sweep, `dut_a`/`dut_b` hold the last vector (all ones) until the next accepted start or reset.
- Back-to-back operation: a `start` at cycle N+LAT+2 (first IDLE cycle) is accepted.

## Structure
- Package `mult_eval_pkg`:
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - width helper constants/functions for N, the `err_cnt` width and the `bit_err_sum` width.
- Sub-module `mult_eval_pipe`: parameterized LAT-deep delay line of {valid, a, b, golden}. At LAT=0 it is a pass-through. It is reset synchronously.
- The popcount and the compare stay in the top level.

## Test plan
- W=2, LAT=0, correct combinational DUT:
  - `start` at cycle 0 → `busy` high for cycles 1–16.
  - `done` at cycle 17.
  - `err_cnt`=0, `bit_err_sum`=0, `ff_valid`=0.
- W=2, LAT=0, DUT with `dut_p` stuck at 0:
  - `err_cnt`=9, `bit_err_sum`=14.
  - `ff_a`=1, `ff_b`=1, `ff_p`=0.
- W=2, LAT=2, correct DUT with a 2-stage registered product:
  - `done` at cycle 19.
  - `err_cnt`=0.
- W=2, LAT=0, DUT with P[0] inverted:
  - `err_cnt`=16, `bit_err_sum`=16.
  - `ff_a`=0, `ff_b`=0, `ff_p`=1.
- Extra `start` pulse at cycle 5 during a sweep:
  - Exactly one `done`, at cycle 17.
  - Results are identical to the first scenario.
- `rst` asserted at cycle 6 during a stuck-at-0 sweep:
  - From cycle 7: `busy`=0, `err_cnt`=0, `ff_valid`=0, `dut_a`=`dut_b`=0.
  - No `done` pulse.
  - A subsequent `start` yields the full stuck-at-0 results.

Source files
------------

// File: rtl/mult_eval_pkg.sv
// Shared types and width helpers for the multiplier evaluation sequencer.
// Widths are derived from the operand width so no counter can overflow.
package mult_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_e;

  function automatic int num_vec(input int w);
    return 1 << (2 * w);
  endfunction

  function automatic int err_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int bes_w(input int w);
    return 2 * w + $clog2(2 * w) + 1;
  endfunction

  function automatic int drn_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mult_eval_pipe.sv
// LAT-deep delay line carrying {valid, operands, golden product}.
// Collapses to a wire at LAT=0; reset clears every stage.
module mult_eval_pipe
  import mult_eval_pkg::*;
#(
  parameter int LAT = 0,
  parameter int DW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_i,
  output logic [DW-1:0] out_o
);

  generate
    if (LAT == 0) begin : g_pass
      assign out_o = in_i;
    end else begin : g_dly
      logic [DW-1:0] stg_q [LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++)
            stg_q[i] <= '0;
        end else begin
          stg_q[0] <= in_i;
          for (int i = 1; i < LAT; i++)
            stg_q[i] <= stg_q[i-1];
        end
      end

      assign out_o = stg_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mult_eval_sequencer.sv
// Sweeps every operand pair through a multiplier candidate and scores it
// against a golden product: mismatch count, bit-error sum, first failure.
module mult_eval_sequencer
  import mult_eval_pkg::*;
#(
  parameter int W   = 2,
  parameter int LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [W-1:0]            dut_a,
  output logic [W-1:0]            dut_b,
  input  logic [2*W-1:0]          dut_p,
  output logic [err_w(W)-1:0]     err_cnt,
  output logic [bes_w(W)-1:0]     bit_err_sum,
  output logic                    ff_valid,
  output logic [W-1:0]            ff_a,
  output logic [W-1:0]            ff_b,
  output logic [2*W-1:0]          ff_p
);

  localparam int PW = 2 * W;
  localparam int EW = err_w(W);
  localparam int BW = bes_w(W);
  localparam int CW = drn_w(LAT);
  localparam int DW = 1 + PW + PW;
  localparam logic [CW-1:0] DRN_LAST = CW'((LAT > 0) ? LAT - 1 : 0);

  state_e        state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [CW-1:0] drn_q, drn_d;
  logic          clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drn_d   = drn_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          drn_d   = '0;
          clr     = 1'b1;
        end
      end
      SWEEP: begin
        if (idx_q == '1) begin
          state_d = (LAT > 0) ? DRAIN : DONE;
        end else begin
          idx_d = idx_q + PW'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == SWEEP) || (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign dut_a = idx_q[PW-1:W];
  assign dut_b = idx_q[W-1:0];

  // Golden travels with its operands so the compare lines up with dut_p
  logic [PW-1:0] gold;
  logic [DW-1:0] pin, pout;
  logic          pv;
  logic [PW-1:0] pidx, pg;

  assign gold = PW'(dut_a) * PW'(dut_b);
  assign pin  = {state_q == SWEEP, idx_q, gold};

  mult_eval_pipe #(
    .LAT (LAT),
    .DW  (DW)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (pin),
    .out_o (pout)
  );

  assign {pv, pidx, pg} = pout;

  function automatic logic [BW-1:0] popcnt(input logic [PW-1:0] v);
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < PW; i++)
      s = s + BW'(v[i]);
    return s;
  endfunction

  logic [PW-1:0] diff;
  logic          mis;

  assign diff = dut_p ^ pg;
  assign mis  = pv && (diff != '0);

  logic [EW-1:0] err_q;
  logic [BW-1:0] bes_q;
  logic          ffv_q;
  logic [PW-1:0] ffi_q;
  logic [PW-1:0] ffp_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_q <= '0;
      bes_q <= '0;
      ffv_q <= 1'b0;
      ffi_q <= '0;
      ffp_q <= '0;
    end else if (mis) begin
      err_q <= err_q + EW'(1);
      bes_q <= bes_q + popcnt(diff);
      if (!ffv_q) begin
        ffv_q <= 1'b1;
        ffi_q <= pidx;
        ffp_q <= dut_p;
      end
    end
  end

  assign err_cnt     = err_q;
  assign bit_err_sum = bes_q;
  assign ff_valid    = ffv_q;
  assign ff_a        = ffi_q[PW-1:W];
  assign ff_b        = ffi_q[W-1:0];
  assign ff_p        = ffp_q;

endmodule

// File: tb/tb_mult_eval_sequencer.sv
// Bench for mult_eval_sequencer: LAT=0 and LAT=2 instances on shared stimulus,
// each scored against a per-cycle model derived from a captured fault table.
module tb_mult_eval_sequencer;

  localparam int W  = 2;
  localparam int N  = 16;
  localparam int PW = 4;
  localparam int EW = 5;
  localparam int BW = 7;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic [PW-1:0] flt [N];

  logic          busy0, done0, ffv0, busy1, done1, ffv1;
  logic [W-1:0]  a0, b0, fa0, fb0, a1, b1, fa1, fb1;
  logic [PW-1:0] p0, fp0, p1, fp1;
  logic [EW-1:0] e0, e1;
  logic [BW-1:0] s0, s1;
  logic [PW-1:0] r1a, r1b;

  mult_eval_sequencer #(.W(W), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .dut_a(a0), .dut_b(b0), .dut_p(p0), .err_cnt(e0), .bit_err_sum(s0),
    .ff_valid(ffv0), .ff_a(fa0), .ff_b(fb0), .ff_p(fp0)
  );

  mult_eval_sequencer #(.W(W), .LAT(2)) u1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .dut_a(a1), .dut_b(b1), .dut_p(p1), .err_cnt(e1), .bit_err_sum(s1),
    .ff_valid(ffv1), .ff_a(fa1), .ff_b(fb1), .ff_p(fp1)
  );

  // Multipliers under test: product XOR a per-vector fault mask
  assign p0 = (PW'(a0) * PW'(b0)) ^ flt[{a0, b0}];
  always @(posedge clk) begin
    r1a <= (PW'(a1) * PW'(b1)) ^ flt[{a1, b1}];
    r1b <= r1a;
  end
  assign p1 = r1b;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  logic st_s, rs_s;
  always @(posedge clk) begin
    st_s <= start;
    rs_s <= rst;
  end

  int       t     [2];
  bit       fresh [2];
  bit       armed = 1'b0;
  logic [PW-1:0] mf [2][N];

  always @(negedge clk) begin
    int L, eb, ed, ei, ee, es, efv, efa, efb, efp, g, p;
    int ab, ad, aa, abb, ae, as, afv, afa, afb, afp;
    string tg;
    if (rs_s === 1'b1) armed = 1'b1;
    for (int d = 0; d < 2; d++) begin
      L = (d == 0) ? 0 : 2;
      if (rs_s === 1'b1) begin
        fresh[d] = 1'b1;
        t[d]     = 0;
      end else if (st_s === 1'b1 && (fresh[d] || t[d] >= N + L + 2)) begin
        fresh[d] = 1'b0;
        t[d]     = 1;
        for (int k = 0; k < N; k++) mf[d][k] = flt[k];
      end else if (!fresh[d] && t[d] < 1000) begin
        t[d]++;
      end
      eb = 0; ed = 0; ei = 0; ee = 0; es = 0;
      efv = 0; efa = 0; efb = 0; efp = 0;
      if (!fresh[d]) begin
        eb = (t[d] >= 1 && t[d] <= N + L) ? 1 : 0;
        ed = (t[d] == N + L + 1) ? 1 : 0;
        ei = (t[d] - 1 < N - 1) ? t[d] - 1 : N - 1;
        for (int k = 0; k < N; k++) begin
          if (k + 2 + L <= t[d]) begin
            g = (k / 4) * (k % 4);
            p = g ^ int'(mf[d][k]);
            if (p != g) begin
              ee++;
              es += $countones(p ^ g);
              if (efv == 0) begin
                efv = 1; efa = k / 4; efb = k % 4; efp = p;
              end
            end
          end
        end
      end
      if (d == 0) begin
        ab = busy0; ad = done0; aa = a0; abb = b0; ae = e0; as = s0;
        afv = ffv0; afa = fa0; afb = fb0; afp = fp0; tg = "L0";
      end else begin
        ab = busy1; ad = done1; aa = a1; abb = b1; ae = e1; as = s1;
        afv = ffv1; afa = fa1; afb = fb1; afp = fp1; tg = "L2";
      end
      if (armed) begin
        chk({tg, " busy"}, ab, eb);
        chk({tg, " done"}, ad, ed);
        chk({tg, " dut_a"}, aa, ei / 4);
        chk({tg, " dut_b"}, abb, ei % 4);
        chk({tg, " err_cnt"}, ae, ee);
        chk({tg, " bit_err_sum"}, as, es);
        chk({tg, " ff_valid"}, afv, efv);
        chk({tg, " ff_a"}, afa, efa);
        chk({tg, " ff_b"}, afb, efb);
        chk({tg, " ff_p"}, afp, efp);
      end
    end
  end

  // One sweep: start sampled at the edge ending cycle 0, optional extra
  // start / reset in a given cycle; reports first done cycle per instance.
  task automatic run(input int xs, input int xr,
                     output int dc0, output int dc1,
                     output int nd0, output int bz19);
    int c;
    dc0 = -1; dc1 = -1; nd0 = 0; bz19 = -1;
    @(posedge clk); #2;
    start = 1'b1;
    @(posedge clk); #2;
    c = 1;
    while (c < 26) begin
      start = (c == xs) ? 1'b1 : 1'b0;
      rst   = (c == xr) ? 1'b1 : 1'b0;
      if (done0) begin
        nd0++;
        if (dc0 < 0) dc0 = c;
      end
      if (done1 && dc1 < 0) dc1 = c;
      if (c == 19) bz19 = busy0;
      @(posedge clk); #2;
      c++;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic set_flt(input int mode);
    for (int k = 0; k < N; k++) begin
      unique case (mode)
        0: flt[k] = '0;
        1: flt[k] = PW'((k / 4) * (k % 4));
        2: flt[k] = PW'(1);
        default: flt[k] = ($urandom_range(0, 2) == 0) ? PW'($urandom) : '0;
      endcase
    end
  endtask

  initial begin
    int dc0, dc1, nd0, bz;
    rst   = 1'b1;
    start = 1'b0;
    set_flt(0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("reset busy", busy0, 0);
    chk("reset err_cnt", e0, 0);

    set_flt(0);
    run(-1, -1, dc0, dc1, nd0, bz);
    chk("clean done cycle L0", dc0, 17);
    chk("clean done cycle L2", dc1, 19);
    chk("clean done count", nd0, 1);
    chk("clean err_cnt", e0, 0);
    chk("clean ff_valid", ffv0, 0);
    chk("clean L2 err_cnt", e1, 0);
    chk("clean busy at 19", bz, 0);

    set_flt(1);
    run(-1, -1, dc0, dc1, nd0, bz);
    chk("stuck0 err_cnt", e0, 9);
    chk("stuck0 bit_err_sum", s0, 14);
    chk("stuck0 ff_a", fa0, 1);
    chk("stuck0 ff_b", fb0, 1);
    chk("stuck0 ff_p", fp0, 0);
    chk("stuck0 L2 err_cnt", e1, 9);

    set_flt(2);
    run(-1, -1, dc0, dc1, nd0, bz);
    chk("p0inv err_cnt", e0, 16);
    chk("p0inv bit_err_sum", s0, 16);
    chk("p0inv ff_a", fa0, 0);
    chk("p0inv ff_b", fb0, 0);
    chk("p0inv ff_p", fp0, 1);

    set_flt(0);
    run(5, -1, dc0, dc1, nd0, bz);
    chk("extra start done cycle", dc0, 17);
    chk("extra start done count", nd0, 1);
    chk("extra start err_cnt", e0, 0);

    set_flt(1);
    run(-1, 6, dc0, dc1, nd0, bz);
    chk("abort done L0", dc0, -1);
    chk("abort done L2", dc1, -1);
    chk("abort busy", busy0, 0);
    chk("abort err_cnt", e0, 0);
    chk("abort ff_valid", ffv0, 0);
    chk("abort dut_a", a0, 0);
    run(-1, -1, dc0, dc1, nd0, bz);
    chk("rerun err_cnt", e0, 9);
    chk("rerun bit_err_sum", s0, 14);

    set_flt(0);
    run(-1, 18, dc0, dc1, nd0, bz);
    run(18, -1, dc0, dc1, nd0, bz);
    chk("back-to-back busy at 19", bz, 1);
    repeat (30) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      set_flt(3);
      run(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 15)) : -1,
          -1, dc0, dc1, nd0, bz);
      chk("random done cycle L0", dc0, 17);
      chk("random done cycle L2", dc1, 19);
    end

    #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
